encoder_8to3_seq: RTL

Sequential 8-to-3 encoder. Accepts an 8-bit multi-hot request word over a valid/ready handshake and emits the 3-bit binary index of every set bit, one index per output handshake, lowest index first. It is the inverse of the team's 3-to-8 one-hot decoder and sits between request-collection logic and any consumer that needs binary select codes, such as a decoder driving one-hot enables.

---
 rtl/encoder_8to3_seq_if.sv | 21 ++
 rtl/encoder_8to3_seq.sv | 99 +++++++++
 2 files changed

// File: rtl/encoder_8to3_seq_if.sv
// Handshake bundle for encoder_8to3_seq: request word in, binary code out.
// master = upstream/consumer side, slave = the encoder.
interface encoder_8to3_seq_if;
  logic [7:0] in;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output in, in_valid, out_ready,
    input  in_ready, out, out_valid, out_last
  );

  modport slave (
    input  in, in_valid, out_ready,
    output in_ready, out, out_valid, out_last
  );
endinterface

// File: rtl/encoder_8to3_seq.sv
// Sequential 8-to-3 encoder: captures a multi-hot word and emits the index
// of each set bit, lowest first, one per output handshake.
// Optional macro ENC_ZERO_ERR_EN adds the zero_err pulse on all-zero captures.
module encoder_8to3_seq (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  encoder_8to3_seq_if.slave         bus,
  output logic                      busy
`ifdef ENC_ZERO_ERR_EN
  ,
  output logic                      zero_err
`endif
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t     r_state;
  logic [7:0] r_pending;
  logic [2:0] r_out;
  logic       r_out_valid;
  logic       r_out_last;
  logic       r_busy;
`ifdef ENC_ZERO_ERR_EN
  logic       r_zero_err;
`endif

  logic       w_in_ready;
  logic       w_capture;
  logic       w_pop;
  logic [7:0] w_next_pending;
  logic [2:0] w_next_idx;
  logic       w_next_last;

  function automatic logic [2:0] lowest_idx(input logic [7:0] p);
    logic [2:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (p[i] && !found) begin
        idx   = 3'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // Handshake decode and the pending word after this edge; outputs are
  // registered from the next pending value so they track it cycle-for-cycle.
  always_comb begin
    w_in_ready     = (r_state == IDLE) && enable && !rst;
    w_capture      = bus.in_valid && w_in_ready;
    w_pop          = r_out_valid && bus.out_ready;
    w_next_pending = r_pending;
    if (w_capture)
      w_next_pending = bus.in;
    else if (w_pop)
      w_next_pending = r_pending & (r_pending - 8'd1);
    w_next_idx  = lowest_idx(w_next_pending);
    w_next_last = (w_next_pending != '0) &&
                  ((w_next_pending & (w_next_pending - 8'd1)) == '0);
  end

  // State, pending bits and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
`ifdef ENC_ZERO_ERR_EN
      r_zero_err  <= 1'b0;
`endif
    end else begin
      r_pending   <= w_next_pending;
      r_state     <= (w_next_pending != '0) ? DRAIN : IDLE;
      r_out       <= w_next_idx;
      r_out_valid <= (w_next_pending != '0);
      r_out_last  <= w_next_last;
      r_busy      <= (w_next_pending != '0);
`ifdef ENC_ZERO_ERR_EN
      r_zero_err  <= w_capture && (bus.in == '0);
`endif
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out       = r_out;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign busy          = r_busy;
`ifdef ENC_ZERO_ERR_EN
  assign zero_err      = r_zero_err;
`endif

endmodule
